// File: rtl/uart_tx.sv
// uart_tx - 8N1 UART transmitter, LSB first, idle-high line.
//
// Bytes are taken over a valid/ready handshake and serialised as one start
// bit (0), DATA_BITS payload bits and one stop bit (1). Every bit lasts
// CLKS_PER_BIT clocks. The line is driven straight from a flop.
//
// Ports:
//   clk      : system clock, all logic on the rising edge
//   rst      : synchronous, active-high reset (aborts any frame in flight)
//   tx_data  : byte to send, sampled only on an accept
//   tx_valid : producer has a byte
//   tx_ready : transmitter can accept (high only in IDLE)
//   tx       : serial line, idle high
//   tx_busy  : high while a frame is in progress
//   tx_done  : one-cycle pulse when the stop bit completes
module uart_tx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 312500,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 busy_q;

  logic baud_last;
  logic accept;

  assign baud_last = (baud_q == BAUD_LAST);
  assign accept    = tx_valid && (state_q == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (baud_last) state_d = DATA;
      DATA:    if (baud_last && (idx_q == IDX_LAST)) state_d = STOP;
      STOP:    if (baud_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter restarts at every state change and at every bit boundary.
    if ((state_q == IDLE) || (state_d != state_q) || baud_last)
      baud_d = '0;
    else
      baud_d = baud_q + 1'b1;

    idx_d = idx_q;
    if (state_q != DATA)
      idx_d = '0;
    else if (baud_last)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    shift_d = shift_q;
    if (accept)
      shift_d = tx_data;
    else if ((state_q == DATA) && baud_last)
      shift_d = shift_q >> 1;
  end

  // Output decode: the line flop is loaded from the upcoming state so the
  // start bit appears on the first cycle after the accept edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && baud_last;
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CPB = 320;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called in the first start-bit cycle; returns in the IDLE-entry cycle.
  // With inject set, a different byte is offered while the frame is in DATA.
  task automatic run_frame(input string name, input logic [7:0] b, input bit inject);
    logic [9:0] fr;
    int good;
    int spur;
    int flag;
    fr   = {1'b1, b, 1'b0};
    spur = 0;
    flag = 0;
    for (int k = 0; k < 10; k++) begin
      good = 0;
      for (int c = 0; c < CPB; c++) begin
        if (inject && k == 3 && c == 0) begin
          tx_data  = 8'hFF;
          tx_valid = 1'b1;
        end
        if (tx === fr[k]) good++;
        if (tx_done !== 1'b0) spur++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) flag++;
        tick();
      end
      chk($sformatf("%s_bit%0d_cycles", name, k), good, CPB);
    end
    chk({name, "_no_early_done"}, spur, 0);
    chk({name, "_busy_not_ready"}, flag, 0);
    chk({name, "_done_pulse"}, int'(tx_done), 1);
    chk({name, "_ready_at_done"}, int'(tx_ready), 1);
    chk({name, "_idle_line"}, int'(tx), 1);
    chk({name, "_busy_low"}, int'(tx_busy), 0);
  endtask

  int t0;
  int cnt;
  int low;

  initial begin
    // Reset with tx_valid high must not start a frame
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    repeat (5) tick();
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    rst      = 1'b0;
    tx_valid = 1'b0;
    tick();
    chk("post_rst_tx", int'(tx), 1);
    chk("post_rst_busy", int'(tx_busy), 0);

    // Idle with tx_valid low: no spurious frames
    low = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) low++;
      tick();
    end
    chk("idle_quiet", low, 0);

    // Single byte 0xA5
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("a5_start_low", int'(tx), 0);
    run_frame("a5", 8'hA5, 1'b0);
    tick();
    chk("a5_done_one_cycle", int'(tx_done), 0);
    chk("a5_stays_idle", int'(tx_busy), 0);

    // Back-to-back 0x00 then 0xFF with tx_valid held
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    t0      = cyc;
    tx_data = 8'hFF;
    run_frame("b2b0", 8'h00, 1'b0);
    tick();
    tx_valid = 1'b0;
    chk("b2b_gap", cyc - t0, 3201);
    run_frame("b2b1", 8'hFF, 1'b0);
    tick();

    // Busy-ignore: 0xFF offered during DATA of 0x3C
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    run_frame("busy3c", 8'h3C, 1'b1);
    tick();
    tx_valid = 1'b0;
    chk("busy_ff_accepted_late", int'(tx), 0);
    run_frame("busyff", 8'hFF, 1'b0);
    tick();

    // Reset at cycle 1000 of a 0x55 frame
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_ready", int'(tx_ready), 1);
    chk("abort_done", int'(tx_done), 0);
    cnt = 0;
    low = 0;
    for (int i = 0; i < 3300; i++) begin
      if (tx_done !== 1'b0) cnt++;
      if (tx !== 1'b1) low++;
      tick();
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_no_resend", low, 0);

    tx_data  = 8'h12;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    run_frame("after_abort12", 8'h12, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
